// File: rtl/tm1638_frame_scheduler.sv
// tm1638_frame_scheduler
// Periodically snapshots the display state and walks the TM1638 command
// protocol one byte at a time over a valid/ready link to the serial byte
// engine. Optionally reads the key matrix back and publishes a key vector.
// Build option: define TM1638_FRAME_KEY_SCAN_EN to include the key read-back
// (RCMD/RDATA/RWAIT). Without it, a frame ends after CTRL and keys stay 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for tick or kick
// MODE  | 0x40 write-data / auto-increment command, STB raised after
// ADDR  | 0xC0 start address
// DATA  | 16 display bytes: even k = digit k/2, odd k = LED k/2
// CTRL  | display control: on/off and brightness
// RCMD  | 0x42 read-keys command
// RDATA | read byte j of 4 requested from the engine
// RWAIT | waiting for the engine to return read byte j
// DONE  | keys published (scan build), then back to IDLE
module tm1638_frame_scheduler #(
  parameter int clk_mhz    = 27,
  parameter int refresh_hz = 100,
  parameter int w_digit    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8*w_digit-1:0] hgfedcba,
  input  logic [7:0]           led,
  input  logic [2:0]           brightness,
  input  logic                 disp_on,
  input  logic                 kick,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_byte,
  output logic                 cmd_read,
  output logic                 cmd_last,
  input  logic                 rsp_valid,
  input  logic [7:0]           rsp_byte,
  output logic [7:0]           keys,
  output logic                 keys_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int PERIOD = clk_mhz * 1000000 / refresh_hz;
  localparam int DIV_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_MODE, S_ADDR, S_DATA, S_CTRL, S_RCMD, S_RDATA, S_RWAIT, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tick;
  logic                 start;
  logic                 accept;
  logic [3:0]           k_q, k_d;
  logic [8*w_digit-1:0] seg_q, seg_d;
  logic [7:0]           led_q, led_d;
  logic [2:0]           bri_q, bri_d;
  logic                 don_q, don_d;
  logic [63:0]          seg_pad;

  logic                 cmd_valid_q, cmd_valid_d;
  logic [7:0]           cmd_byte_q, cmd_byte_d;
  logic                 cmd_read_q, cmd_read_d;
  logic                 cmd_last_q, cmd_last_d;
  logic                 busy_q;
  logic                 ovr_q, ovr_d;

`ifdef TM1638_FRAME_KEY_SCAN_EN
  logic [1:0]           j_q, j_d;
  logic [7:0]           rbyte_q [4];
  logic [7:0]           rbyte_d [4];
  logic [7:0]           keys_q, keys_d;
  logic                 keys_valid_q, keys_valid_d;
`endif

  // Free-running frame-rate divider; kick never disturbs its phase.
  assign tick   = (div_q == DIV_LAST);
  assign div_d  = tick ? '0 : div_q + DIV_W'(1);
  assign start  = tick | kick;
  assign accept = cmd_valid_q & cmd_ready;

  // Next-state logic: advance on handshake, snapshot inputs at frame start.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    seg_d   = seg_q;
    led_d   = led_q;
    bri_d   = bri_q;
    don_d   = don_q;
    ovr_d   = 1'b0;
`ifdef TM1638_FRAME_KEY_SCAN_EN
    j_d          = j_q;
    rbyte_d      = rbyte_q;
    keys_d       = keys_q;
    keys_valid_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MODE;
          seg_d   = hgfedcba;
          led_d   = led;
          bri_d   = brightness;
          don_d   = disp_on;
        end
      end
      S_MODE: if (accept) state_d = S_ADDR;
      S_ADDR: begin
        if (accept) begin
          state_d = S_DATA;
          k_d     = '0;
        end
      end
      S_DATA: begin
        if (accept) begin
          if (k_q == 4'd15) state_d = S_CTRL;
          k_d = k_q + 4'd1;
        end
      end
      S_CTRL: begin
        if (accept) begin
`ifdef TM1638_FRAME_KEY_SCAN_EN
          state_d = S_RCMD;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef TM1638_FRAME_KEY_SCAN_EN
      S_RCMD: begin
        if (accept) begin
          state_d = S_RDATA;
          j_d     = '0;
        end
      end
      S_RDATA: if (accept) state_d = S_RWAIT;
      S_RWAIT: begin
        if (rsp_valid) begin
          rbyte_d[j_q] = rsp_byte;
          if (j_q == 2'd3) begin
            state_d      = S_DONE;
            keys_valid_d = 1'b1;
            // Each read byte carries two key columns in bits 0 and 4.
            for (int i = 0; i < 4; i++) begin
              keys_d[i]     = rbyte_d[i][0];
              keys_d[i + 4] = rbyte_d[i][4];
            end
          end else begin
            state_d = S_RDATA;
            j_d     = j_q + 2'd1;
          end
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Requests that land on a running frame are dropped, never queued.
    if (start && (state_q != S_IDLE)) ovr_d = 1'b1;
  end

  // Command fields for the state being entered, so outputs come straight from flops.
  always_comb begin
    cmd_valid_d = 1'b0;
    cmd_byte_d  = 8'h00;
    cmd_read_d  = 1'b0;
    cmd_last_d  = 1'b0;
    // Digits beyond w_digit read as zero through the padding.
    seg_pad     = 64'(seg_d);
    case (state_d)
      S_MODE: begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = 8'h40;
        cmd_last_d  = 1'b1;
      end
      S_ADDR: begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = 8'hC0;
      end
      S_DATA: begin
        cmd_valid_d = 1'b1;
        cmd_last_d  = (k_d == 4'd15);
        if (k_d[0]) cmd_byte_d = {7'b0, led_d[k_d[3:1]]};
        else        cmd_byte_d = seg_pad[{k_d[3:1], 3'b000} +: 8];
      end
      S_CTRL: begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = don_d ? {5'b10001, bri_d} : 8'h80;
        cmd_last_d  = 1'b1;
      end
`ifdef TM1638_FRAME_KEY_SCAN_EN
      S_RCMD: begin
        cmd_valid_d = 1'b1;
        cmd_byte_d  = 8'h42;
      end
      S_RDATA: begin
        cmd_valid_d = 1'b1;
        cmd_read_d  = 1'b1;
        cmd_last_d  = (j_d == 2'd3);
      end
`endif
      default: ;
    endcase
  end

  // Divider, FSM state and shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      state_q <= S_IDLE;
      k_q     <= '0;
      seg_q   <= '0;
      led_q   <= '0;
      bri_q   <= '0;
      don_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      state_q <= state_d;
      k_q     <= k_d;
      seg_q   <= seg_d;
      led_q   <= led_d;
      bri_q   <= bri_d;
      don_q   <= don_d;
    end
  end

  // Registered command and status outputs; reset drops cmd_valid at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= '0;
      cmd_read_q  <= 1'b0;
      cmd_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_read_q  <= cmd_read_d;
      cmd_last_q  <= cmd_last_d;
      busy_q      <= (state_d != S_IDLE);
      ovr_q       <= ovr_d;
    end
  end

`ifdef TM1638_FRAME_KEY_SCAN_EN
  // Read index, captured key bytes and published key vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q <= '0;
      for (int i = 0; i < 4; i++) rbyte_q[i] <= '0;
      keys_q       <= '0;
      keys_valid_q <= 1'b0;
    end else begin
      j_q          <= j_d;
      rbyte_q      <= rbyte_d;
      keys_q       <= keys_d;
      keys_valid_q <= keys_valid_d;
    end
  end

  assign keys       = keys_q;
  assign keys_valid = keys_valid_q;
`else
  logic unused_rsp;
  assign unused_rsp = ^{rsp_valid, rsp_byte};
  assign keys       = 8'h00;
  assign keys_valid = 1'b0;
`endif

  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign cmd_read  = cmd_read_q;
  assign cmd_last  = cmd_last_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_tm1638_frame_scheduler.sv
// Testbench for tm1638_frame_scheduler: two instances (8 and 4 digits) share
// stimulus and are compared cycle by cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_tm1638_frame_scheduler;
  localparam int CLK_MHZ    = 1;
  localparam int REFRESH_HZ = 25000;
  localparam int P          = CLK_MHZ * 1000000 / REFRESH_HZ;
`ifdef TM1638_FRAME_KEY_SCAN_EN
  localparam bit SCAN = 1'b1;
  localparam int NB   = 24;
`else
  localparam bit SCAN = 1'b0;
  localparam int NB   = 19;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] hgfedcba;
  logic [7:0]  led;
  logic [2:0]  brightness;
  logic        disp_on, kick, cmd_ready, rsp_valid;
  logic [7:0]  rsp_byte;

  logic       a_valid, a_read, a_last, a_kv, a_busy, a_ovr;
  logic [7:0] a_byte, a_keys;
  logic       b_valid, b_read, b_last, b_kv, b_busy, b_ovr;
  logic [7:0] b_byte, b_keys;

  always #5 clk = ~clk;

  tm1638_frame_scheduler #(.clk_mhz(CLK_MHZ), .refresh_hz(REFRESH_HZ), .w_digit(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .hgfedcba(hgfedcba), .led(led), .brightness(brightness),
    .disp_on(disp_on), .kick(kick), .cmd_valid(a_valid), .cmd_ready(cmd_ready),
    .cmd_byte(a_byte), .cmd_read(a_read), .cmd_last(a_last), .rsp_valid(rsp_valid),
    .rsp_byte(rsp_byte), .keys(a_keys), .keys_valid(a_kv), .busy(a_busy), .overrun(a_ovr));

  tm1638_frame_scheduler #(.clk_mhz(CLK_MHZ), .refresh_hz(REFRESH_HZ), .w_digit(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .hgfedcba(hgfedcba[31:0]), .led(led), .brightness(brightness),
    .disp_on(disp_on), .kick(kick), .cmd_valid(b_valid), .cmd_ready(cmd_ready),
    .cmd_byte(b_byte), .cmd_read(b_read), .cmd_last(b_last), .rsp_valid(rsp_valid),
    .rsp_byte(rsp_byte), .keys(b_keys), .keys_valid(b_kv), .busy(b_busy), .overrun(b_ovr));

  typedef enum logic [1:0] {M_IDLE, M_ACT, M_DONE} mph_t;

  mph_t       ph;
  int         div_m, idx, nrsp, rsp_cnt, n_b;
  bit         wait_r, ovr_e, kv_e;
  logic [7:0] keys_e;
  logic [7:0] eb8 [24];
  logic [7:0] eb4 [24];
  bit         erd [24];
  bit         elast [24];
  logic [7:0] rb [4];
  logic [7:0] rsp_plan [4];
  bit         stall_en, chg_en, spur_en, hold_rsp, fixed_rsp, busy_prev;
  int         max_delay, dut_frames, cyc_no;
  int         n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  task automatic put(input logic [7:0] b8, input logic [7:0] b4, input bit rd, input bit lst);
    eb8[n_b] = b8; eb4[n_b] = b4; erd[n_b] = rd; elast[n_b] = lst;
    n_b++;
  endtask

  // Expected byte list for one frame, from the inputs seen at frame start.
  task automatic build_frame();
    logic [7:0] s;
    n_b = 0;
    put(8'h40, 8'h40, 1'b0, 1'b1);
    put(8'hC0, 8'hC0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) begin
        s = hgfedcba[8*(k/2) +: 8];
        put(s, (k/2 < 4) ? s : 8'h00, 1'b0, k == 15);
      end else begin
        s = {7'b0, led[k/2]};
        put(s, s, 1'b0, k == 15);
      end
    end
    s = disp_on ? (8'h88 | {5'b0, brightness}) : 8'h80;
    put(s, s, 1'b0, 1'b1);
    put(8'h42, 8'h42, 1'b0, 1'b0);
    for (int j = 0; j < 4; j++) put(8'h00, 8'h00, 1'b1, j == 3);
    if (fixed_rsp) begin
      rsp_plan[0] = 8'h11; rsp_plan[1] = 8'h00; rsp_plan[2] = 8'h10; rsp_plan[3] = 8'h01;
    end else begin
      for (int j = 0; j < 4; j++) rsp_plan[j] = 8'($urandom);
    end
  endtask

  task automatic enter_done();
    ph = M_DONE;
    kv_e = SCAN;
    if (SCAN) begin
      for (int j = 0; j < 4; j++) begin
        keys_e[j]     = rb[j][0];
        keys_e[j + 4] = rb[j][4];
      end
    end
  endtask

  // One clock edge of the reference model, using the inputs the bench drove.
  task automatic model_edge();
    bit tick, start;
    tick  = (div_m == P - 1);
    div_m = tick ? 0 : div_m + 1;
    start = tick || kick;
    ovr_e = 1'b0;
    kv_e  = 1'b0;
    case (ph)
      M_IDLE: if (start) begin
        build_frame();
        idx = 0; nrsp = 0; wait_r = 1'b0; ph = M_ACT;
      end
      M_ACT: begin
        if (start) ovr_e = 1'b1;
        if (wait_r) begin
          if (rsp_valid) begin
            rb[nrsp] = rsp_byte;
            nrsp++;
            wait_r = 1'b0;
            if (nrsp == 4) enter_done();
          end
        end else if (cmd_ready) begin
          idx++;
          if (erd[idx-1]) begin
            wait_r  = 1'b1;
            rsp_cnt = int'($urandom_range(max_delay, 1));
          end else if (idx == NB) enter_done();
        end
      end
      default: begin
        if (start) ovr_e = 1'b1;
        ph = M_IDLE;
      end
    endcase
  endtask

  task automatic check_outputs();
    bit v;
    v = (ph == M_ACT) && !wait_r && (idx < NB);
    chk("cmd_valid", 32'(a_valid), 32'(v));
    chk("cmd_valid_w4", 32'(b_valid), 32'(v));
    if (v) begin
      chk("cmd_read_last", 32'({a_read, a_last}), 32'({erd[idx], elast[idx]}));
      chk("cmd_read_last_w4", 32'({b_read, b_last}), 32'({erd[idx], elast[idx]}));
      if (!erd[idx]) begin
        chk("cmd_byte", 32'(a_byte), 32'(eb8[idx]));
        chk("cmd_byte_w4", 32'(b_byte), 32'(eb4[idx]));
      end
    end
    chk("busy", 32'({a_busy, b_busy}), 32'({ph != M_IDLE, ph != M_IDLE}));
    chk("overrun", 32'({a_ovr, b_ovr}), 32'({ovr_e, ovr_e}));
    chk("keys", 32'({a_kv, a_keys}), 32'({kv_e, keys_e}));
    chk("keys_w4", 32'({b_kv, b_keys}), 32'({kv_e, keys_e}));
    if (a_busy && !busy_prev) dut_frames++;
    busy_prev = a_busy;
  endtask

  task automatic cyc();
    cmd_ready = stall_en ? ($urandom_range(2) != 0) : 1'b1;
    if (wait_r && !hold_rsp && rsp_cnt <= 1) begin
      rsp_valid = 1'b1;
      rsp_byte  = rsp_plan[nrsp];
    end else begin
      if (wait_r && !hold_rsp) rsp_cnt--;
      rsp_valid = spur_en && !wait_r && ($urandom_range(3) == 0);
      rsp_byte  = 8'($urandom);
    end
    if (chg_en) begin
      hgfedcba   = {$urandom, $urandom};
      led        = 8'($urandom);
      brightness = 3'($urandom);
      disp_on    = 1'($urandom);
    end
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    kick = 1'b0;
    cyc_no++;
  endtask

  task automatic reset_model();
    ph = M_IDLE; div_m = 0; idx = 0; nrsp = 0; wait_r = 1'b0;
    ovr_e = 1'b0; kv_e = 1'b0; keys_e = 8'h00; busy_prev = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300; i++) begin
      if (ph == M_IDLE) break;
      cyc();
    end
    if (i == 300) chk("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_tick_idle();
    int i;
    for (i = 0; i < 400; i++) begin
      if (ph == M_IDLE && div_m == P - 1) break;
      cyc();
    end
    if (i == 400) chk("wait_tick_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t_kv, t_idle, f0, i;
    n_chk = 0; n_err = 0; cyc_no = 0; dut_frames = 0;
    stall_en = 0; chg_en = 0; spur_en = 0; hold_rsp = 0; fixed_rsp = 1; max_delay = 1;
    kick = 0; cmd_ready = 1; rsp_valid = 0; rsp_byte = 0;
    hgfedcba = 64'h0; led = 8'h0; brightness = 3'd0; disp_on = 1'b0;
    reset_model();
    #2;
    chk("reset_outputs", 32'({a_valid, a_byte, a_read, a_last, a_keys, a_kv, a_busy, a_ovr}), 32'd0);
    chk("reset_outputs_w4", 32'({b_valid, b_byte, b_read, b_last, b_keys, b_kv, b_busy, b_ovr}), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    reset_model();

    // Directed frame: digit0=0x3F, led=0x01, brightness 7, display on.
    hgfedcba = 64'h3F; led = 8'h01; brightness = 3'd7; disp_on = 1'b1;
    kick = 1'b1;
    cyc();
    t0 = cyc_no; t_kv = t0 - 1; t_idle = -1;
    chk("first_byte", 32'({a_valid, a_byte}), 32'h140);
    for (i = 0; i < 80; i++) begin
      cyc();
      if (a_kv) t_kv = cyc_no;
      if (!a_busy) begin
        t_idle = cyc_no;
        break;
      end
    end
    chk("kv_latency", 32'(t_kv - t0 + 1), SCAN ? 32'd29 : 32'd0);
    chk("busy_length", 32'(t_idle - t0), SCAN ? 32'd29 : 32'd20);
    chk("keys_directed", 32'(a_keys), SCAN ? 32'h59 : 32'h00);

    // Tick and kick together start one frame; a kick one cycle later overruns.
    wait_tick_idle();
    f0 = dut_frames;
    kick = 1'b1;
    cyc();
    chk("tick_kick_no_ovr", 32'(a_ovr), 32'd0);
    kick = 1'b1;
    cyc();
    chk("kick_after_start_ovr", 32'(a_ovr), 32'd1);
    for (i = 0; i < 80 && a_busy; i++) cyc();
    chk("tick_kick_frames", 32'(dut_frames - f0), 32'd1);

`ifdef TM1638_FRAME_KEY_SCAN_EN
    // Tick while waiting for a read byte is dropped with one overrun.
    wait_idle();
    fixed_rsp = 0;
    f0 = dut_frames;
    hold_rsp = 1'b1;
    kick = 1'b1;
    cyc();
    for (i = 0; i < 300; i++) begin
      if (wait_r && div_m == P - 1) break;
      cyc();
    end
    cyc();
    chk("tick_rwait_ovr", 32'(a_ovr), 32'd1);
    hold_rsp = 1'b0;
    for (i = 0; i < 80 && a_busy; i++) cyc();
    chk("tick_rwait_frames", 32'(dut_frames - f0), 32'd1);
`endif

    // Reset in the middle of DATA k=7, then restart from 0x40.
    wait_idle();
    hgfedcba = {$urandom, $urandom}; led = 8'($urandom);
    kick = 1'b1;
    cyc();
    for (i = 0; i < 60; i++) begin
      if (ph == M_ACT && idx == 9 && !wait_r) break;
      cyc();
    end
    chk("reached_data_k7", 32'(a_byte), 32'(eb8[9]));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cmd_valid", 32'({a_valid, b_valid}), 32'd0);
    chk("rst_busy", 32'({a_busy, b_busy}), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    reset_model();
    kick = 1'b1;
    cyc();
    chk("restart_byte", 32'({a_valid, a_byte}), 32'h140);
    wait_idle();

    // Random stalls, late/spurious responses, inputs changing every cycle.
    stall_en = 1; chg_en = 1; spur_en = 1; max_delay = 3; fixed_rsp = 0;
    repeat (3000) begin
      kick = ($urandom_range(30) == 0);
      cyc();
    end
    stall_en = 0; chg_en = 0; spur_en = 0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
